msrv32_lsu_ctrl: RTL and testbench

Load/store controller consuming the effective address produced by the immediate adder (rs1 + imm) and turning it into a single-outstanding data-memory transaction. Generates word-aligned address, byte strobes and replicated write data for stores, performs lane extraction and sign/zero extension for loads, stalls the pipeline while the access is in flight and flags misaligned, illegal and timed-out accesses. Sits between the execute-stage address path and the data-memory port of the msrv32 core.

---
 rtl/msrv32_pkg.sv | 50 +++++
 rtl/msrv32_load_align.sv | 33 +++
 rtl/msrv32_lsu_ctrl.sv | 125 ++++++++++++
 tb/tb_msrv32_lsu_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared msrv32 LSU definitions: funct3 access codes, LSU state encoding and store lane helpers.
// Pure declarations. No timing and no flow control.
package msrv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // funct3[1:0] carries the access size for both the signed and the unsigned forms.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b01:   return lane[0];
            2'b10:   return |lane;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Load result formatter: picks the byte/half lane from the read word and sign- or zero-extends it.
// Purely combinational. No flow control.
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/msrv32_lsu_ctrl.sv
// Load/store controller: one outstanding data-memory access at a time. Zero-wait access takes 3 cycles, request to DONE.
// stall_out holds upstream while a request is accepted or in flight. The request is held until ack or timeout.
module msrv32_lsu_ctrl
    import msrv32_pkg::*;
#(
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_rd_req_in,
    input  logic        mem_wr_req_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wstrb_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    lsu_state_t  state;
    logic [29:0] addr_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [7:0]  cnt;
    logic [31:0] load_data_q;
    logic        misaligned_q;
    logic        bus_err_q;

    logic        req;
    logic        legal;
    logic        misal;
    logic [31:0] aligned_data;

    assign req   = mem_wr_req_in | mem_rd_req_in;
    assign legal = f3_legal(funct3_in, mem_wr_req_in);
    assign misal = f3_misaligned(funct3_in, iadder_in[1:0]);

    msrv32_load_align u_load_align (
        .rdata  (dmem_rdata_in),
        .lane   (lane_q),
        .funct3 (funct3_q),
        .result (aligned_data)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state        <= LSU_IDLE;
            addr_q       <= '0;
            lane_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt          <= '0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (req) begin
                        if (!legal) begin
                            bus_err_q <= 1'b1;
                        end else if (misal) begin
                            misaligned_q <= 1'b1;
                        end else begin
                            // Store wins when both requests are raised together.
                            addr_q   <= iadder_in[31:2];
                            lane_q   <= iadder_in[1:0];
                            funct3_q <= funct3_in;
                            we_q     <= mem_wr_req_in;
                            wdata_q  <= mem_wr_req_in ? store_wdata(funct3_in, rs2_in) : '0;
                            wstrb_q  <= mem_wr_req_in ? store_wstrb(funct3_in, iadder_in[1:0]) : 4'b0000;
                            cnt      <= '0;
                            state    <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (dmem_ack_in) begin
                        if (!we_q)
                            load_data_q <= aligned_data;
                        state <= LSU_DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_err_q <= 1'b1;
                        state     <= LSU_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LSU_DONE: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

    assign dmem_req_out   = (state == LSU_REQ);
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = {addr_q, 2'b00};
    assign dmem_wdata_out = wdata_q;
    assign dmem_wstrb_out = wstrb_q;
    assign load_data_out  = load_data_q;
    assign load_valid_out = (state == LSU_DONE) && !we_q;
    assign misaligned_out = misaligned_q;
    assign bus_err_out    = bus_err_q;
    assign stall_out      = ((state == LSU_IDLE) && req && legal && !misal) || (state == LSU_REQ);

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// Directed bench for msrv32_lsu_ctrl: loads, stores, misaligned/illegal, timeout and mid-access reset.
module tb_msrv32_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iadder_in = '0;
    logic [31:0] rs2_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        mem_rd_req_in = 1'b0;
    logic        mem_wr_req_in = 1'b0;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_wstrb_out;
    logic        dmem_ack_in = 1'b0;
    logic [31:0] dmem_rdata_in = '0;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        stall_out;
    logic        misaligned_out;
    logic        bus_err_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .iadder_in            (iadder_in),
        .rs2_in               (rs2_in),
        .funct3_in            (funct3_in),
        .mem_rd_req_in        (mem_rd_req_in),
        .mem_wr_req_in        (mem_wr_req_in),
        .dmem_req_out         (dmem_req_out),
        .dmem_we_out          (dmem_we_out),
        .dmem_addr_out        (dmem_addr_out),
        .dmem_wdata_out       (dmem_wdata_out),
        .dmem_wstrb_out       (dmem_wstrb_out),
        .dmem_ack_in          (dmem_ack_in),
        .dmem_rdata_in        (dmem_rdata_in),
        .load_data_out        (load_data_out),
        .load_valid_out       (load_valid_out),
        .stall_out            (stall_out),
        .misaligned_out       (misaligned_out),
        .bus_err_out          (bus_err_out)
    );

    // Stimulus only: issues one access, acks after 'waits' wait cycles, returns at the negedge of the DONE cycle.
    task automatic run_access(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] d, input int waits, input logic [31:0] rdata,
                              output logic o_stall0, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                              output logic [3:0] o_wstrb, output logic o_we, output int o_req_cycles,
                              output logic o_lv);
        @(posedge clk); #1;
        mem_wr_req_in = wr; mem_rd_req_in = !wr; iadder_in = addr; funct3_in = f3; rs2_in = d;
        @(negedge clk);
        o_stall0 = stall_out;
        @(posedge clk); #1;
        mem_wr_req_in = 1'b0; mem_rd_req_in = 1'b0;
        o_req_cycles = 0;
        o_addr = 'x; o_wdata = 'x; o_wstrb = 'x; o_we = 1'bx;
        for (int i = 0; i <= waits; i++) begin
            dmem_ack_in = (i == waits);
            dmem_rdata_in = rdata;
            @(negedge clk);
            if (dmem_req_out) begin
                o_req_cycles++;
                o_addr = dmem_addr_out; o_wdata = dmem_wdata_out; o_wstrb = dmem_wstrb_out; o_we = dmem_we_out;
            end
            @(posedge clk); #1;
        end
        dmem_ack_in = 1'b0;
        @(negedge clk);
        o_lv = load_valid_out;
    endtask

    task automatic test_reset();
        logic [127:0] v;
        v = {dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wstrb_out,
             load_data_out, load_valid_out, stall_out, misaligned_out, bus_err_out};
        checks++; if (v !== 128'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v); end
        checks++; if (dmem_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req_out); end
    endtask

    task automatic test_lw();
        logic s0, we, lv; logic [31:0] a, wd; logic [3:0] ws; int rc;
        run_access(1'b0, 32'h100, 3'b010, 32'h0, 0, 32'hDEADBEEF, s0, a, wd, ws, we, rc, lv);
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL lw_stall0: got %b want 1", s0); end
        checks++; if (a !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 00000100", a); end
        checks++; if (ws !== 4'b0000) begin errors++; $display("FAIL lw_wstrb: got %b want 0000", ws); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL lw_we: got %b want 0", we); end
        checks++; if (rc !== 1) begin errors++; $display("FAIL lw_req_cycles: got %0d want 1", rc); end
        checks++; if (lv !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b want 1", lv); end
        checks++; if (load_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", load_data_out); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lw_done_stall: got %b want 0", stall_out); end
        @(negedge clk);
        checks++; if (load_valid_out !== 1'b0) begin errors++; $display("FAIL lw_valid_pulse: got %b want 0", load_valid_out); end
    endtask

    task automatic test_load_ext();
        logic [31:0] addrs [5] = '{32'h203, 32'h203, 32'h201, 32'h202, 32'h202};
        logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b000, 3'b101, 3'b001};
        logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00000000, 32'h000080FF, 32'hFFFF80FF};
        logic s0, we, lv; logic [31:0] a, wd; logic [3:0] ws; int rc;
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, addrs[i], f3s[i], 32'h0, 1, 32'h80FF0000, s0, a, wd, ws, we, rc, lv);
            checks++; if (load_data_out !== exps[i]) begin errors++; $display("FAIL load_ext[%0d]: got %h want %h", i, load_data_out, exps[i]); end
            checks++; if (a !== 32'h200 || rc !== 2 || lv !== 1'b1) begin
                errors++; $display("FAIL load_ext_bus[%0d]: addr %h cycles %0d valid %b want 00000200 2 1", i, a, rc, lv); end
        end
    endtask

    task automatic test_store();
        logic [31:0] addrs [3] = '{32'h301, 32'h302, 32'h304};
        logic [2:0]  f3s   [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] ea    [3] = '{32'h300, 32'h300, 32'h304};
        logic [31:0] ewd   [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
        logic [3:0]  ews   [3] = '{4'b0010, 4'b1100, 4'b1111};
        logic s0, we, lv; logic [31:0] a, wd; logic [3:0] ws; int rc;
        for (int i = 0; i < 3; i++) begin
            run_access(1'b1, addrs[i], f3s[i], 32'h12345678, 0, 32'h0BAD0BAD, s0, a, wd, ws, we, rc, lv);
            checks++; if (a !== ea[i] || wd !== ewd[i] || ws !== ews[i] || we !== 1'b1) begin
                errors++; $display("FAIL store[%0d]: addr %h wdata %h wstrb %b we %b want %h %h %b 1", i, a, wd, ws, we, ea[i], ewd[i], ews[i]); end
            checks++; if (lv !== 1'b0) begin errors++; $display("FAIL store_valid[%0d]: got %b want 0", i, lv); end
            checks++; if (load_data_out !== 32'hFFFF80FF) begin errors++; $display("FAIL store_hold[%0d]: got %h want ffff80ff", i, load_data_out); end
        end
    endtask

    // Rejected requests: misaligned (expect_bus_err=0) or illegal funct3 (expect_bus_err=1).
    task automatic test_reject(input string name, input logic wr, input logic [31:0] addr,
                               input logic [2:0] f3, input logic expect_bus_err);
        @(posedge clk); #1;
        mem_wr_req_in = wr; mem_rd_req_in = !wr; iadder_in = addr; funct3_in = f3;
        @(negedge clk);
        checks++; if (stall_out !== 1'b0 || dmem_req_out !== 1'b0) begin
            errors++; $display("FAIL %s_c0: stall %b req %b want 0 0", name, stall_out, dmem_req_out); end
        @(posedge clk); #1;
        mem_wr_req_in = 1'b0; mem_rd_req_in = 1'b0;
        @(negedge clk);
        checks++; if (misaligned_out !== !expect_bus_err || bus_err_out !== expect_bus_err || dmem_req_out !== 1'b0) begin
            errors++; $display("FAIL %s_pulse: mis %b err %b req %b want %b %b 0", name, misaligned_out, bus_err_out, dmem_req_out, !expect_bus_err, expect_bus_err); end
        @(negedge clk);
        checks++; if (misaligned_out !== 1'b0 || bus_err_out !== 1'b0 || dmem_req_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL %s_after: mis %b err %b req %b stall %b want 0 0 0 0", name, misaligned_out, bus_err_out, dmem_req_out, stall_out); end
    endtask

    task automatic test_timeout();
        logic s0, we, lv; logic [31:0] a, wd; logic [3:0] ws; int rc;
        @(posedge clk); #1;
        mem_rd_req_in = 1'b1; iadder_in = 32'h104; funct3_in = 3'b010;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            mem_rd_req_in = 1'b0;
            @(negedge clk);
            checks++; if (dmem_req_out !== 1'b1 || bus_err_out !== 1'b0) begin
                errors++; $display("FAIL timeout_req[%0d]: req %b err %b want 1 0", c, dmem_req_out, bus_err_out); end
        end
        @(negedge clk);
        checks++; if (bus_err_out !== 1'b1 || dmem_req_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL timeout_err: err %b req %b stall %b want 1 0 0", bus_err_out, dmem_req_out, stall_out); end
        @(negedge clk);
        checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b want 0", bus_err_out); end
        // Ack in the 4th REQ cycle beats the timeout.
        run_access(1'b0, 32'h108, 3'b010, 32'h0, 3, 32'hA5A5_0F0F, s0, a, wd, ws, we, rc, lv);
        checks++; if (rc !== 4 || lv !== 1'b1 || load_data_out !== 32'hA5A50F0F) begin
            errors++; $display("FAIL ack_at_limit: cycles %0d valid %b data %h want 4 1 a5a50f0f", rc, lv, load_data_out); end
        checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL ack_at_limit_err_done: got %b want 0", bus_err_out); end
        @(negedge clk);
        checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL ack_at_limit_err_next: got %b want 0", bus_err_out); end
    endtask

    task automatic test_reset_mid();
        logic s0, we, lv; logic [31:0] a, wd; logic [3:0] ws; int rc;
        @(posedge clk); #1;
        mem_rd_req_in = 1'b1; iadder_in = 32'h100; funct3_in = 3'b010;
        @(posedge clk); #1;
        mem_rd_req_in = 1'b0;
        @(negedge clk);
        checks++; if (dmem_req_out !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b want 1", dmem_req_out); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (dmem_req_out !== 1'b0 || stall_out !== 1'b0 || dmem_addr_out !== 32'h0 || load_data_out !== 32'h0) begin
            errors++; $display("FAIL rstmid_async: req %b stall %b addr %h data %h want 0 0 0 0", dmem_req_out, stall_out, dmem_addr_out, load_data_out); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'h11111111;
        @(negedge clk);
        checks++; if (dmem_req_out !== 1'b0 || load_valid_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL late_ack: req %b valid %b stall %b want 0 0 0", dmem_req_out, load_valid_out, stall_out); end
        @(posedge clk); #1;
        dmem_ack_in = 1'b0;
        @(negedge clk);
        checks++; if (load_valid_out !== 1'b0 || load_data_out !== 32'h0) begin
            errors++; $display("FAIL late_ack_data: valid %b data %h want 0 0", load_valid_out, load_data_out); end
        run_access(1'b0, 32'h100, 3'b010, 32'h0, 0, 32'hCAFEF00D, s0, a, wd, ws, we, rc, lv);
        checks++; if (lv !== 1'b1 || load_data_out !== 32'hCAFEF00D || rc !== 1) begin
            errors++; $display("FAIL post_reset_lw: valid %b data %h cycles %0d want 1 cafef00d 1", lv, load_data_out, rc); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_reject("mis_lw", 1'b0, 32'h102, 3'b010, 1'b0);
        test_reject("mis_sh", 1'b1, 32'h101, 3'b001, 1'b0);
        test_reject("mis_lhu", 1'b0, 32'h203, 3'b101, 1'b0);
        test_reject("ill_load", 1'b0, 32'h100, 3'b011, 1'b1);
        test_reject("ill_store", 1'b1, 32'h100, 3'b100, 1'b1);
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
